// File: rtl/wb_trace_tx.sv
// wb_trace_tx
//   Logs register-file writebacks as ASCII text over a UART line.
//   Each accepted event becomes one 13-character line:
//     <2-char register name> '=' <8 uppercase hex digits> CR LF
//   Characters are sent as 8N1 frames. Events wait in a small FIFO while
//   earlier lines are still being sent. If the FIFO is full, new events are
//   dropped and the sticky overflow flag is set.
//
//   Parameters:
//     CLK_DIV    clock cycles per UART bit (2..65535)
//     FIFO_DEPTH pending events held (power of two, 2..16)
//
//   Ports:
//     clk       rising-edge clock
//     resetn    asynchronous active-low reset
//     wb_en     writeback strobe; one event per asserted cycle
//     wb_addr   destination register number
//     wb_data   value written
//     tx        UART serial output, idle high
//     busy      high unless idle with an empty FIFO
//     overflow  sticky: an event was dropped (cleared only by reset)
//
//   Build option:
//     WB_TRACE_SKIP_R0_EN  when defined, writes to register 0 are ignored.
//                          They are not pushed and cannot set overflow.
module wb_trace_tx #(
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        tx,
  output logic        busy,
  output logic        overflow
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP} state_t;
  state_t r_state, w_state_next;

  logic [36:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic [4:0]    r_line_addr;
  logic [31:0]   r_line_data;
  logic [CW-1:0] r_baud, w_baud_next;
  logic [2:0]    r_bit, w_bit_next;
  logic [3:0]    r_char, w_char_next;
  logic          w_push_req, w_full, w_pop, w_push, w_baud_last;
  logic [15:0]   w_name;
  logic [7:0]    w_char;
  logic [3:0]    w_nib_pos, w_nib;

  function automatic logic [7:0] f_hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [15:0] f_name(input logic [4:0] a);
    logic [7:0] d;
    d = {3'b000, a};
    if (a == 5'd0)       f_name = "$0";
    else if (a == 5'd1)  f_name = "at";
    else if (a <= 5'd3)  f_name = {"v", 8'h30 + d - 8'd2};
    else if (a <= 5'd7)  f_name = {"a", 8'h30 + d - 8'd4};
    else if (a <= 5'd15) f_name = {"t", 8'h30 + d - 8'd8};
    else if (a <= 5'd23) f_name = {"s", 8'h30 + d - 8'd16};
    else if (a <= 5'd25) f_name = {"t", 8'h30 + d - 8'd16};  // t8, t9
    else if (a <= 5'd27) f_name = {"k", 8'h30 + d - 8'd26};
    else if (a == 5'd28) f_name = "gp";
    else if (a == 5'd29) f_name = "sp";
    else if (a == 5'd30) f_name = "fp";
    else                 f_name = "ra";
  endfunction

`ifdef WB_TRACE_SKIP_R0_EN
  assign w_push_req = wb_en && (wb_addr != 5'd0);
`else
  assign w_push_req = wb_en;
`endif

  // The only pop happens in LOAD. A push in that same cycle can be
  // accepted even when the FIFO is full.
  assign w_full = (r_count == FULL_CNT);
  assign w_pop  = (r_state == S_LOAD);
  assign w_push = w_push_req && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {wb_addr, wb_data};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_line_addr <= '0;
      r_line_data <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr                     <= r_rd_ptr + AW'(1);
        {r_line_addr, r_line_data}   <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_push_req && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_char  <= '0;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_char  <= w_char_next;
    end
  end

  assign w_baud_last = (r_baud == BAUD_LAST);

  // The baud counter restarts on every bit boundary. The bit counter and
  // character index are reset only by state transitions, so they never wrap.
  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit;
    w_char_next  = r_char;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        w_state_next = S_START;
        w_baud_next  = '0;
        w_char_next  = '0;
      end
      S_START: begin
        if (w_baud_last) begin
          w_baud_next  = '0;
          w_bit_next   = '0;
          w_state_next = S_DATA;
        end else begin
          w_baud_next = r_baud + CW'(1);
        end
      end
      S_DATA: begin
        if (w_baud_last) begin
          w_baud_next = '0;
          if (r_bit == 3'd7) w_state_next = S_STOP;
          else               w_bit_next   = r_bit + 3'd1;
        end else begin
          w_baud_next = r_baud + CW'(1);
        end
      end
      S_STOP: begin
        if (w_baud_last) begin
          w_baud_next = '0;
          if (r_char == 4'd12) begin
            w_state_next = (r_count != '0) ? S_LOAD : S_IDLE;
          end else begin
            w_char_next  = r_char + 4'd1;
            w_state_next = S_START;
          end
        end else begin
          w_baud_next = r_baud + CW'(1);
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Build the current character directly from the line register.
  // Character index 3 selects the top nibble, and index 10 selects the
  // bottom nibble.
  always_comb begin
    w_name    = f_name(r_line_addr);
    w_nib_pos = 4'd10 - r_char;
    w_nib     = r_line_data[{w_nib_pos[2:0], 2'b00} +: 4];
    if (r_char == 4'd0)       w_char = w_name[15:8];
    else if (r_char == 4'd1)  w_char = w_name[7:0];
    else if (r_char == 4'd2)  w_char = 8'h3D;
    else if (r_char <= 4'd10) w_char = f_hex(w_nib);
    else if (r_char == 4'd11) w_char = 8'h0D;
    else                      w_char = 8'h0A;
  end

  // tx is decoded from state only, so asynchronous reset drives it high at once.
  always_comb begin
    tx = 1'b1;
    case (r_state)
      S_START: tx = 1'b0;
      S_DATA:  tx = w_char[r_bit];
      default: tx = 1'b1;
    endcase
  end

  assign busy     = (r_state != S_IDLE) || (r_count != '0);
  assign overflow = r_overflow;

endmodule
